// File: rtl/monitor_breakpoints.sv
// Hardware breakpoint monitor. A small table of address/bank breakpoints is
// watched against instruction-load, memory-read and memory-write strobes.
// Each entry has a pass count that must run down to zero before it halts.
// A configuration port reads and writes the entries.
//
// Handshake: the event strobes and cfg_we/cfg_re are single-cycle qualifiers
// sampled on every rising SIM_CLK edge (no ready/backpressure). halt_req is a
// level that stays high until the cycle halt_clr is sampled high.
module monitor_breakpoints #(
    parameter int NUM_BP = 4,
    parameter int IDX_W  = 2
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST,
    input  logic             ev_inst,
    input  logic             ev_rd,
    input  logic             ev_wr,
    input  logic [11:0]      s_addr,
    input  logic [14:0]      bb_in,
    input  logic             cfg_we,
    input  logic             cfg_re,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [1:0]       cfg_field,
    input  logic [15:0]      cfg_wdata,
    output logic [15:0]      cfg_rdata,
    output logic             halt_req,
    output logic [IDX_W-1:0] halt_idx,
    input  logic             halt_clr,
    output logic [15:0]      hit_total
);

    // halt_req is the registered FSM state itself.
    localparam logic ARMED  = 1'b0;
    localparam logic HALTED = 1'b1;

    localparam logic [IDX_W:0] NUM_BP_L = (IDX_W+1)'(NUM_BP);

    logic [11:0]      addr_q    [NUM_BP];
    logic [11:0]      addr_d    [NUM_BP];
    logic [14:0]      bank_q    [NUM_BP];
    logic [14:0]      bank_d    [NUM_BP];
    logic             oneshot_q [NUM_BP];
    logic             oneshot_d [NUM_BP];
    logic [1:0]       mode_q    [NUM_BP];
    logic [1:0]       mode_d    [NUM_BP];
    logic [7:0]       pass_q    [NUM_BP];
    logic [7:0]       pass_d    [NUM_BP];

    logic             state_q, state_d;
    logic [IDX_W-1:0] halt_idx_q, halt_idx_d;
    logic [15:0]      hit_q, hit_d;
    logic [15:0]      rdata_q, rdata_d;

    logic             idx_ok;
    logic [NUM_BP-1:0] match;
    logic             any_hit;
    logic [IDX_W-1:0] sel;

    assign idx_ok    = ({1'b0, cfg_idx} < NUM_BP_L);
    assign halt_req  = state_q;
    assign halt_idx  = halt_idx_q;
    assign hit_total = hit_q;
    assign cfg_rdata = rdata_q;

    // Per-entry match and lowest-index priority select. An entry being
    // written this cycle is excluded so the write takes precedence.
    always_comb begin
        logic strobe;
        logic bank_ok;
        match   = '0;
        any_hit = 1'b0;
        sel     = '0;
        for (int k = 0; k < NUM_BP; k++) begin
            case (mode_q[k])
                2'd1:    strobe = ev_inst;
                2'd2:    strobe = ev_rd;
                2'd3:    strobe = ev_wr;
                default: strobe = 1'b0;
            endcase
            if (s_addr[11:10] != 2'b01)
                bank_ok = 1'b1;
            else if (bb_in[14:13] == 2'b11)
                bank_ok = (bb_in[14:4] == bank_q[k][14:4]);
            else
                bank_ok = (bb_in[14:10] == bank_q[k][14:10]);
            match[k] = strobe && (s_addr == addr_q[k]) && bank_ok &&
                       !(cfg_we && idx_ok && (cfg_idx == IDX_W'(k)));
        end
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            if (match[k]) begin
                any_hit = 1'b1;
                sel     = IDX_W'(k);
            end
        end
    end

    // Next-state: config read/write, then processing of the selected match.
    always_comb begin
        addr_d     = addr_q;
        bank_d     = bank_q;
        oneshot_d  = oneshot_q;
        mode_d     = mode_q;
        pass_d     = pass_q;
        state_d    = state_q;
        halt_idx_d = halt_idx_q;
        hit_d      = hit_q;
        rdata_d    = rdata_q;

        // Reads return the pre-write value when a write lands the same cycle.
        if (cfg_re) begin
            rdata_d = '0;
            if (idx_ok) begin
                case (cfg_field)
                    2'd0:    rdata_d = {4'd0, addr_q[cfg_idx]};
                    2'd1:    rdata_d = {1'b0, bank_q[cfg_idx]};
                    2'd2:    rdata_d = {13'd0, oneshot_q[cfg_idx], mode_q[cfg_idx]};
                    default: rdata_d = {8'd0, pass_q[cfg_idx]};
                endcase
            end
        end

        if (cfg_we && idx_ok) begin
            case (cfg_field)
                2'd0: addr_d[cfg_idx] = cfg_wdata[11:0];
                2'd1: bank_d[cfg_idx] = cfg_wdata[14:0];
                2'd2: begin
                    oneshot_d[cfg_idx] = cfg_wdata[2];
                    mode_d[cfg_idx]    = cfg_wdata[1:0];
                end
                default: pass_d[cfg_idx] = cfg_wdata[7:0];
            endcase
        end

        // halt_clr reopens evaluation in the same cycle it clears the halt.
        if (state_q == ARMED || halt_clr) begin
            state_d = ARMED;
            if (any_hit) begin
                if (pass_q[sel] != 8'd0) begin
                    pass_d[sel] = pass_q[sel] - 8'd1;
                end else begin
                    state_d    = HALTED;
                    halt_idx_d = sel;
                    if (hit_q != 16'hFFFF)
                        hit_d = hit_q + 16'd1;
                    if (oneshot_q[sel])
                        mode_d[sel] = 2'd0;
                end
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            for (int k = 0; k < NUM_BP; k++) begin
                addr_q[k]    <= '0;
                bank_q[k]    <= '0;
                oneshot_q[k] <= 1'b0;
                mode_q[k]    <= '0;
                pass_q[k]    <= '0;
            end
            state_q    <= ARMED;
            halt_idx_q <= '0;
            hit_q      <= '0;
            rdata_q    <= '0;
        end else begin
            addr_q     <= addr_d;
            bank_q     <= bank_d;
            oneshot_q  <= oneshot_d;
            mode_q     <= mode_d;
            pass_q     <= pass_d;
            state_q    <= state_d;
            halt_idx_q <= halt_idx_d;
            hit_q      <= hit_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_monitor_breakpoints.sv
// Directed test for monitor_breakpoints: address/bank matching, pass counts,
// priority, oneshot, halt/clear overlap, write-wins, and async reset.
module tb_monitor_breakpoints;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST = 1'b0;
    logic        ev_inst = 1'b0;
    logic        ev_rd = 1'b0;
    logic        ev_wr = 1'b0;
    logic [11:0] s_addr = '0;
    logic [14:0] bb_in = '0;
    logic        cfg_we = 1'b0;
    logic        cfg_re = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [1:0]  cfg_field = '0;
    logic [15:0] cfg_wdata = '0;
    logic [15:0] cfg_rdata;
    logic        halt_req;
    logic [1:0]  halt_idx;
    logic        halt_clr = 1'b0;
    logic [15:0] hit_total;

    int total = 0;
    int bad = 0;
    logic [15:0] rd;

    monitor_breakpoints #(.NUM_BP(4), .IDX_W(2)) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
        .ev_inst(ev_inst), .ev_rd(ev_rd), .ev_wr(ev_wr),
        .s_addr(s_addr), .bb_in(bb_in),
        .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_idx(cfg_idx),
        .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .halt_req(halt_req), .halt_idx(halt_idx), .halt_clr(halt_clr),
        .hit_total(hit_total)
    );

    // Clock
    always #5 SIM_CLK = ~SIM_CLK;

    // One clock edge; outputs are looked at 1 time unit after it.
    task automatic tick();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [1:0] fld, input logic [15:0] data);
        cfg_we = 1'b1; cfg_idx = idx; cfg_field = fld; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] idx, input logic [1:0] fld, output logic [15:0] data);
        cfg_re = 1'b1; cfg_idx = idx; cfg_field = fld;
        tick();
        cfg_re = 1'b0;
        data = cfg_rdata;
    endtask

    // kind: 1 = inst, 2 = read, 3 = write
    task automatic fire(input int kind, input logic [11:0] a, input logic [14:0] bb);
        s_addr = a; bb_in = bb;
        ev_inst = (kind == 1); ev_rd = (kind == 2); ev_wr = (kind == 3);
        tick();
        ev_inst = 1'b0; ev_rd = 1'b0; ev_wr = 1'b0;
    endtask

    task automatic pulse_clr();
        halt_clr = 1'b1;
        tick();
        halt_clr = 1'b0;
    endtask

    task automatic setup(input logic [1:0] idx, input logic [11:0] a, input logic [14:0] bk,
                         input logic [2:0] ctrl, input logic [7:0] pc);
        cfg_write(idx, 2'd0, {4'd0, a});
        cfg_write(idx, 2'd1, {1'b0, bk});
        cfg_write(idx, 2'd3, {8'd0, pc});
        cfg_write(idx, 2'd2, {13'd0, ctrl});
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_halt_req", {15'd0, halt_req}, 16'd0);
        check("rst_halt_idx", {14'd0, halt_idx}, 16'd0);
        check("rst_hit_total", hit_total, 16'd0);
        check("rst_rdata", cfg_rdata, 16'd0);
        SIM_RST = 1'b1;
        tick();

        // Bank-qualified instruction breakpoint, FB=5
        setup(2'd0, 12'o2000, 15'h1400, 3'b001, 8'd0);
        fire(1, 12'o2000, 15'h1400);
        check("bank_hit_req", {15'd0, halt_req}, 16'd1);
        check("bank_hit_idx", {14'd0, halt_idx}, 16'd0);
        check("bank_hit_total", hit_total, 16'd1);
        pulse_clr();
        check("clr_req", {15'd0, halt_req}, 16'd0);
        fire(1, 12'o2000, 15'h1800);
        check("bank_miss_req", {15'd0, halt_req}, 16'd0);
        check("bank_miss_total", hit_total, 16'd1);
        pulse_clr();
        check("clr_armed_noeffect", {15'd0, halt_req}, 16'd0);

        // Pass-count countdown on write breakpoint
        setup(2'd1, 12'o0100, 15'h0000, 3'b011, 8'd2);
        fire(3, 12'o0100, 15'h0000);
        check("pass_1st_req", {15'd0, halt_req}, 16'd0);
        fire(3, 12'o0100, 15'h0000);
        check("pass_2nd_req", {15'd0, halt_req}, 16'd0);
        fire(3, 12'o0100, 15'h0000);
        check("pass_3rd_req", {15'd0, halt_req}, 16'd1);
        check("pass_3rd_idx", {14'd0, halt_idx}, 16'd1);
        check("pass_3rd_total", hit_total, 16'd2);
        cfg_read(2'd1, 2'd3, rd);
        check("pass_readback", rd, 16'd0);
        pulse_clr();

        // Priority: entries 0 and 2 match the same read
        setup(2'd0, 12'h123, 15'h0000, 3'b010, 8'd0);
        setup(2'd2, 12'h123, 15'h0000, 3'b010, 8'd3);
        fire(2, 12'h123, 15'h0000);
        check("prio_req", {15'd0, halt_req}, 16'd1);
        check("prio_idx", {14'd0, halt_idx}, 16'd0);
        check("prio_total", hit_total, 16'd3);
        cfg_read(2'd2, 2'd3, rd);
        check("prio_e2_pass", rd, 16'd3);
        pulse_clr();

        // Oneshot entry 3
        setup(2'd3, 12'h200, 15'h0000, 3'b101, 8'd0);
        fire(1, 12'h200, 15'h0000);
        check("oneshot_req", {15'd0, halt_req}, 16'd1);
        check("oneshot_idx", {14'd0, halt_idx}, 16'd3);
        check("oneshot_total", hit_total, 16'd4);
        pulse_clr();
        fire(1, 12'h200, 15'h0000);
        check("oneshot_rpt_req", {15'd0, halt_req}, 16'd0);
        check("oneshot_rpt_total", hit_total, 16'd4);
        cfg_read(2'd3, 2'd2, rd);
        check("oneshot_ctrl", rd, 16'h0004);

        // Halted ignores matches; halt_clr plus new match re-halts
        fire(2, 12'h123, 15'h0000);
        check("halt_e0_req", {15'd0, halt_req}, 16'd1);
        check("halt_e0_total", hit_total, 16'd5);
        fire(2, 12'h123, 15'h0000);
        check("halted_ignore_total", hit_total, 16'd5);
        check("halted_ignore_idx", {14'd0, halt_idx}, 16'd0);
        cfg_write(2'd3, 2'd2, 16'h0001);
        halt_clr = 1'b1;
        fire(1, 12'h200, 15'h0000);
        halt_clr = 1'b0;
        check("clr_match_req", {15'd0, halt_req}, 16'd1);
        check("clr_match_idx", {14'd0, halt_idx}, 16'd3);
        check("clr_match_total", hit_total, 16'd6);
        pulse_clr();

        // Config write to entry 3 wins over its match
        cfg_we = 1'b1; cfg_idx = 2'd3; cfg_field = 2'd0; cfg_wdata = 16'h0200;
        fire(1, 12'h200, 15'h0000);
        cfg_we = 1'b0;
        check("wwin_req", {15'd0, halt_req}, 16'd0);
        check("wwin_total", hit_total, 16'd6);

        // Simultaneous write and read return the old value
        cfg_we = 1'b1; cfg_re = 1'b1; cfg_idx = 2'd2; cfg_field = 2'd3; cfg_wdata = 16'h0007;
        tick();
        cfg_we = 1'b0; cfg_re = 1'b0;
        check("rw_old", cfg_rdata, 16'd3);
        cfg_read(2'd2, 2'd3, rd);
        check("rw_new", rd, 16'd7);

        // Async reset while halted with a countdown at 5
        cfg_write(2'd2, 2'd3, 16'h0005);
        fire(2, 12'h123, 15'h0000);
        check("prerst_req", {15'd0, halt_req}, 16'd1);
        #2;
        SIM_RST = 1'b0;
        #1;
        check("arst_req", {15'd0, halt_req}, 16'd0);
        check("arst_idx", {14'd0, halt_idx}, 16'd0);
        check("arst_total", hit_total, 16'd0);
        check("arst_rdata", cfg_rdata, 16'd0);
        tick();
        SIM_RST = 1'b1;
        cfg_read(2'd2, 2'd3, rd);
        check("arst_e2_pass", rd, 16'd0);
        cfg_read(2'd0, 2'd2, rd);
        check("arst_e0_ctrl", rd, 16'd0);
        cfg_read(2'd0, 2'd0, rd);
        check("arst_e0_addr", rd, 16'd0);
        fire(2, 12'h123, 15'h0000);
        check("arst_nohalt", {15'd0, halt_req}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
